// File: rtl/swo_uart_rx.sv
// SWO NRZ/UART (8N1, LSB first) receiver with programmable bit period.
// Recovered bytes are offered to the trace logic through a one-deep valid/ready holding register.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE      | line idle, waiting for a falling edge while enabled
//   START     | counting to the middle of the start bit to reject glitches
//   DATA      | sampling the eight data bits, one every bit period
//   STOP      | sampling the stop bit; high completes the byte
//   WAIT_IDLE | framing error seen, waiting for the line to return high
module swo_uart_rx #(
    parameter int pDIV_WIDTH   = 12,
    parameter int pSYNC_STAGES = 2
) (
    input  logic                  fe_clk,
    input  logic                  reset,
    input  logic                  I_swo,
    input  logic                  I_enable,
    input  logic [pDIV_WIDTH-1:0] I_clocks_per_bit,
    input  logic                  I_data_ready,
    input  logic                  I_clear_errors,
    output logic [7:0]            O_data,
    output logic                  O_data_valid,
    output logic                  O_framing_error,
    output logic                  O_overrun,
    output logic                  O_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t                  state, state_nxt;
    logic [pSYNC_STAGES-1:0] sync_q;
    logic                    line;
    logic [pDIV_WIDTH-1:0]   cpb_in;
    logic [pDIV_WIDTH-1:0]   cpb_q, cpb_nxt;
    logic [pDIV_WIDTH-1:0]   cnt_q, cnt_nxt;
    logic [2:0]              bit_idx_q, bit_idx_nxt;
    logic [7:0]              shift_q, shift_nxt;
    logic                    tick;
    logic                    byte_done;
    logic                    frame_err;

    always_ff @(posedge fe_clk or posedge reset) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[pSYNC_STAGES-2:0], I_swo};
        end
    end

    assign line   = sync_q[pSYNC_STAGES-1];
    assign cpb_in = (I_clocks_per_bit < pDIV_WIDTH'(4)) ? pDIV_WIDTH'(4) : I_clocks_per_bit;
    assign tick   = (cnt_q == '0);
    assign O_busy = (state != ST_IDLE);

    always_ff @(posedge fe_clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            cpb_q     <= '0;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state     <= state_nxt;
            cpb_q     <= cpb_nxt;
            cnt_q     <= cnt_nxt;
            bit_idx_q <= bit_idx_nxt;
            shift_q   <= shift_nxt;
        end
    end

    // Counter saturates at zero; every sample point reloads it with cpb-1.
    always_comb begin
        state_nxt   = state;
        cpb_nxt     = cpb_q;
        cnt_nxt     = tick ? cnt_q : cnt_q - pDIV_WIDTH'(1);
        bit_idx_nxt = bit_idx_q;
        shift_nxt   = shift_q;
        byte_done   = 1'b0;
        frame_err   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (I_enable && !line) begin
                    state_nxt = ST_START;
                    cpb_nxt   = cpb_in;
                    cnt_nxt   = (cpb_in >> 1) - pDIV_WIDTH'(1);
                end
            end
            ST_START: begin
                if (tick) begin
                    if (line) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt   = ST_DATA;
                        bit_idx_nxt = '0;
                        cnt_nxt     = cpb_q - pDIV_WIDTH'(1);
                    end
                end
            end
            ST_DATA: begin
                if (tick) begin
                    shift_nxt = {line, shift_q[7:1]};
                    cnt_nxt   = cpb_q - pDIV_WIDTH'(1);
                    if (bit_idx_q == 3'd7) begin
                        state_nxt = ST_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx_q + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (line) begin
                        byte_done = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        frame_err = 1'b1;
                        state_nxt = ST_WAIT_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                if (line) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase

        // Disabling aborts any frame in flight, including one finishing this cycle.
        if (!I_enable) begin
            state_nxt = ST_IDLE;
            byte_done = 1'b0;
            frame_err = 1'b0;
        end
    end

    always_ff @(posedge fe_clk or posedge reset) begin
        if (reset) begin
            O_data          <= '0;
            O_data_valid    <= 1'b0;
            O_framing_error <= 1'b0;
            O_overrun       <= 1'b0;
        end else begin
            O_framing_error <= frame_err;

            if (byte_done) begin
                if (O_data_valid && !I_data_ready) begin
                    O_overrun <= 1'b1;
                end else begin
                    O_data       <= shift_q;
                    O_data_valid <= 1'b1;
                end
            end else if (O_data_valid && I_data_ready) begin
                O_data_valid <= 1'b0;
            end

            if (!(byte_done && O_data_valid && !I_data_ready) && I_clear_errors) begin
                O_overrun <= 1'b0;
            end
        end
    end

endmodule
